// File: rtl/if0_pcgen_pkg.sv
// Shared widths, reset constants, state encoding and buffer payload for the first fetch stage.
package if0_pcgen_pkg;

  localparam int unsigned REG_W      = 32;
  localparam int unsigned INST_BYTES = 4;

  localparam logic [REG_W-1:0] LOONG_PC_START_ADDR = 32'h1C00_0000;
  localparam logic [REG_W-1:0] LOONG_NOP_INST      = 32'h0340_0000;

  typedef enum logic [1:0] {
    IF0_REQ  = 2'd0,
    IF0_WAIT = 2'd1,
    IF0_HOLD = 2'd2
  } if0_state_e;

  // One buffered fetch result as presented to the next stage.
  typedef struct packed {
    logic [REG_W-1:0] pc;
    logic [REG_W-1:0] inst;
    logic             adef;
  } if0_entry_t;

  // A fetch PC is legal only when word aligned.
  function automatic logic pc_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/if0_pcgen_if.sv
// Instruction-SRAM request/response bus between the fetch stage and memory.
interface if0_pcgen_if;
  import if0_pcgen_pkg::*;

  logic             inst_sram_req;
  logic [REG_W-1:0] inst_sram_addr;
  logic             inst_sram_addr_ok;
  logic             inst_sram_data_ok;
  logic [REG_W-1:0] inst_sram_rdata;

  modport master (
    output inst_sram_req,
    output inst_sram_addr,
    input  inst_sram_addr_ok,
    input  inst_sram_data_ok,
    input  inst_sram_rdata
  );

  modport slave (
    input  inst_sram_req,
    input  inst_sram_addr,
    output inst_sram_addr_ok,
    output inst_sram_data_ok,
    output inst_sram_rdata
  );
endinterface

// File: rtl/if0_pcgen_redirect_mux.sv
// Redirect request and target select; exceptions win over branches.
module if0_pcgen_redirect_mux
  import if0_pcgen_pkg::*;
(
  input  logic             i_excp,
  input  logic [REG_W-1:0] i_excp_target,
  input  logic             i_br_taken,
  input  logic [REG_W-1:0] i_br_target,
  output logic             o_redirect_c,
  output logic [REG_W-1:0] o_tgt_c
);

  // Any redirect source flushes the fetch stream.
  assign o_redirect_c = i_excp | i_br_taken;
  // Exception/ertn target has priority over a branch in the same cycle.
  assign o_tgt_c      = i_excp ? i_excp_target : i_br_target;

endmodule

// File: rtl/if0_pcgen.sv
// First fetch stage: owns the fetch PC, issues one SRAM request at a time,
// buffers one returned instruction and handles redirects with response discard.
module if0_pcgen
  import if0_pcgen_pkg::*;
#(
  parameter logic [REG_W-1:0] RESET_PC = LOONG_PC_START_ADDR,
  parameter logic [REG_W-1:0] NOP_INST = LOONG_NOP_INST
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ctl_if_allow_nxt_pc_i,
  input  logic             br_taken_i,
  input  logic [REG_W-1:0] br_target_i,
  input  logic             excp_i,
  input  logic [REG_W-1:0] excp_target_i,
  if0_pcgen_if.master      sram,
  output logic             if_valid_o,
  output logic [REG_W-1:0] if_pc_o,
  output logic [REG_W-1:0] if_inst_o,
  output logic             if_adef_o
);

  localparam int unsigned ADDR_W = REG_W;

  if0_state_e        r_state;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic              r_discard;
  logic              r_req;
  logic              r_valid;
  if0_entry_t        r_buf;

  logic              w_redirect;
  logic [ADDR_W-1:0] w_tgt;
  logic              w_acc;
  logic [ADDR_W-1:0] w_pc_inc;

  if0_pcgen_redirect_mux u_redirect_mux (
    .i_excp        (excp_i),
    .i_excp_target (excp_target_i),
    .i_br_taken    (br_taken_i),
    .i_br_target   (br_target_i),
    .o_redirect_c  (w_redirect),
    .o_tgt_c       (w_tgt)
  );

  // A request counts as accepted only while it is actually being driven.
  assign w_acc    = r_req & sram.inst_sram_addr_ok;
  assign w_pc_inc = r_fetch_pc + ADDR_W'(INST_BYTES);

  // Fetch FSM; req is precomputed for the state/PC being entered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IF0_REQ;
      r_fetch_pc <= RESET_PC;
      r_discard  <= 1'b0;
      r_req      <= 1'b0;
      r_valid    <= 1'b0;
      r_buf      <= '{pc: '0, inst: NOP_INST, adef: 1'b0};
    end else begin
      case (r_state)
        IF0_REQ: begin
          if (w_redirect) begin
            r_fetch_pc <= w_tgt;
            if (w_acc) begin
              // The request just accepted belongs to the old PC.
              r_state   <= IF0_WAIT;
              r_discard <= 1'b1;
              r_req     <= 1'b0;
            end else begin
              r_req <= pc_aligned(w_tgt[1:0]);
            end
          end else if (!pc_aligned(r_fetch_pc[1:0])) begin
            // Misaligned fetch: no memory access, deliver a faulting NOP.
            r_state <= IF0_HOLD;
            r_valid <= 1'b1;
            r_buf   <= '{pc: r_fetch_pc, inst: NOP_INST, adef: 1'b1};
            r_req   <= 1'b0;
          end else if (w_acc) begin
            r_state <= IF0_WAIT;
            r_req   <= 1'b0;
          end else begin
            r_req <= 1'b1;
          end
        end

        IF0_WAIT: begin
          r_req <= 1'b0;
          if (w_redirect) begin
            r_fetch_pc <= w_tgt;
            if (sram.inst_sram_data_ok) begin
              // Response arrives with the redirect: drop it and refetch.
              r_discard <= 1'b0;
              r_state   <= IF0_REQ;
              r_req     <= pc_aligned(w_tgt[1:0]);
            end else begin
              r_discard <= 1'b1;
            end
          end else if (sram.inst_sram_data_ok) begin
            if (r_discard) begin
              r_discard <= 1'b0;
              r_state   <= IF0_REQ;
              r_req     <= pc_aligned(r_fetch_pc[1:0]);
            end else begin
              r_state <= IF0_HOLD;
              r_valid <= 1'b1;
              r_buf   <= '{pc: r_fetch_pc, inst: sram.inst_sram_rdata, adef: 1'b0};
            end
          end
        end

        IF0_HOLD: begin
          r_req <= 1'b0;
          if (w_redirect) begin
            // Redirect beats a simultaneous downstream capture.
            r_valid    <= 1'b0;
            r_fetch_pc <= w_tgt;
            r_state    <= IF0_REQ;
            r_req      <= pc_aligned(w_tgt[1:0]);
          end else if (ctl_if_allow_nxt_pc_i) begin
            r_valid    <= 1'b0;
            r_fetch_pc <= w_pc_inc;
            r_state    <= IF0_REQ;
            r_req      <= pc_aligned(w_pc_inc[1:0]);
          end
        end

        default: begin
          r_state <= IF0_REQ;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  // Memory contract: a response only ever arrives while one is awaited.
  a_data_ok_only_in_wait: assert property (
    @(posedge clk_i) disable iff (rst_i)
    sram.inst_sram_data_ok |-> (r_state == IF0_WAIT)
  );

  assign sram.inst_sram_req  = r_req;
  assign sram.inst_sram_addr = r_fetch_pc;

  assign if_valid_o = r_valid;
  assign if_pc_o    = r_buf.pc;
  assign if_inst_o  = r_buf.inst;
  assign if_adef_o  = r_buf.adef;

endmodule

// File: tb/tb_if0_pcgen.sv
// Bench for if0_pcgen: directed corner sequences, a redirect vector table,
// and randomized traffic checked against a fetch-stream reference model.
module tb_if0_pcgen;

  localparam logic [31:0] RST_PC = 32'h1C00_0000;
  localparam logic [31:0] NOP    = 32'h0340_0000;

  logic        clk;
  logic        rst;
  logic        allow;
  logic        br_taken;
  logic [31:0] br_tgt;
  logic        excp;
  logic [31:0] excp_tgt;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        adef;

  if0_pcgen_if u_if ();

  if0_pcgen #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .ctl_if_allow_nxt_pc_i (allow),
    .br_taken_i            (br_taken),
    .br_target_i           (br_tgt),
    .excp_i                (excp),
    .excp_target_i         (excp_tgt),
    .sram                  (u_if),
    .if_valid_o            (valid),
    .if_pc_o               (pc),
    .if_inst_o             (inst),
    .if_adef_o             (adef)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;
  int cyc;
  int okp;
  int lat;
  int dok_cnt;
  logic        pend_v;
  logic [31:0] pend_a;
  int          pend_c;

  typedef struct {
    logic        excp;
    logic        br;
    logic [31:0] etgt;
    logic [31:0] btgt;
    logic [31:0] epc;
    logic [31:0] einst;
    logic        eadef;
    logic [31:0] enext;
  } vec_t;

  vec_t        tbl [6];
  logic [31:0] pool [8];

  task automatic chk(input string nm, input logic ok, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (ok === 1'b1) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
  endtask

  // Advance one cycle; memory model: one outstanding request, rdata = ~addr,
  // data_ok `lat` cycles after acceptance.
  task automatic tick();
    logic        acc;
    logic        dok;
    logic [31:0] a;
    acc = u_if.inst_sram_req && u_if.inst_sram_addr_ok;
    dok = u_if.inst_sram_data_ok;
    a   = u_if.inst_sram_addr;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      pend_v = 1'b0;
    end else begin
      if (dok) begin
        pend_v = 1'b0;
        dok_cnt++;
      end
      if (acc) begin
        pend_v = 1'b1;
        pend_a = a;
        pend_c = lat - 1;
      end else if (pend_v && pend_c > 0) begin
        pend_c--;
      end
    end
    u_if.inst_sram_data_ok = pend_v && (pend_c == 0) && !rst;
    u_if.inst_sram_rdata   = ~pend_a;
    u_if.inst_sram_addr_ok = u_if.inst_sram_req && !rst && (int'($urandom_range(99)) < okp);
  endtask

  task automatic wait_valid(input string nm, input int max);
    int n;
    n = 0;
    while (!valid && n < max) begin
      tick();
      n++;
    end
    chk(nm, valid, 32'(valid), 32'd1);
  endtask

  task automatic wait_req(input string nm, input int max);
    int n;
    n = 0;
    while (!(u_if.inst_sram_req && u_if.inst_sram_addr_ok) && n < max) begin
      tick();
      n++;
    end
    chk(nm, u_if.inst_sram_req && u_if.inst_sram_addr_ok, 32'(u_if.inst_sram_req), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int          n_acc;
    logic [31:0] p0;
    logic [31:0] i0;
    logic        bad;
    logic        saw_req;
    int          n;
    int          d0;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic        redir;
    logic [31:0] tgt;
    int          ncap;
    int          r;

    tbl[0] = '{excp:1'b0, br:1'b1, etgt:32'h0,          btgt:32'h1C00_0102, epc:32'h1C00_0102, einst:NOP,          eadef:1'b1, enext:32'h1C00_0106};
    tbl[1] = '{excp:1'b1, br:1'b1, etgt:32'h0000_0003,  btgt:32'h1C00_0000, epc:32'h0000_0003, einst:NOP,          eadef:1'b1, enext:32'h0000_0007};
    tbl[2] = '{excp:1'b0, br:1'b1, etgt:32'h0,          btgt:32'hFFFF_FFFC, epc:32'hFFFF_FFFC, einst:32'h0000_0003, eadef:1'b0, enext:32'h0000_0000};
    tbl[3] = '{excp:1'b1, br:1'b0, etgt:32'h1C00_4000,  btgt:32'h0,         epc:32'h1C00_4000, einst:32'hE3FF_BFFF, eadef:1'b0, enext:32'h1C00_4004};
    tbl[4] = '{excp:1'b0, br:1'b1, etgt:32'h0,          btgt:32'hFFFF_FFFE, epc:32'hFFFF_FFFE, einst:NOP,          eadef:1'b1, enext:32'h0000_0002};
    tbl[5] = '{excp:1'b0, br:1'b1, etgt:32'h0,          btgt:32'h8000_0000, epc:32'h8000_0000, einst:32'h7FFF_FFFF, eadef:1'b0, enext:32'h8000_0004};

    pool[0] = 32'h1C00_0000; pool[1] = 32'h1C00_0100; pool[2] = 32'h1C00_4000; pool[3] = 32'h0000_2000;
    pool[4] = 32'hFFFF_FFF8; pool[5] = 32'h1C00_0102; pool[6] = 32'h0000_0003; pool[7] = 32'h8000_0010;

    n_chk = 0; n_pass = 0; cyc = 0; dok_cnt = 0;
    okp = 100; lat = 2;
    pend_v = 1'b0; pend_a = '0; pend_c = 0;
    rst = 1'b1; allow = 1'b0; br_taken = 1'b0; excp = 1'b0; br_tgt = '0; excp_tgt = '0;
    u_if.inst_sram_addr_ok = 1'b0;
    u_if.inst_sram_data_ok = 1'b0;
    u_if.inst_sram_rdata   = '0;

    // Reset values
    repeat (3) tick();
    chk("rst_req",   !u_if.inst_sram_req, 32'(u_if.inst_sram_req), 32'd0);
    chk("rst_valid", !valid,              32'(valid),              32'd0);
    chk("rst_pc",    pc == 32'd0,         pc,                      32'd0);
    chk("rst_inst",  inst == NOP,         inst,                    NOP);
    chk("rst_adef",  !adef,               32'(adef),               32'd0);

    // First fetch after reset with allow=1
    rst = 1'b0;
    allow = 1'b1;
    wait_req("first_req_wait", 10);
    chk("first_req_addr", u_if.inst_sram_addr == RST_PC, u_if.inst_sram_addr, RST_PC);
    n_acc = cyc;
    wait_valid("first_valid_wait", 10);
    chk("first_latency", (cyc - n_acc) == 3, 32'(cyc - n_acc), 32'd3);
    chk("first_pc",   pc == RST_PC,    pc,   RST_PC);
    chk("first_inst", inst == ~RST_PC, inst, ~RST_PC);
    tick();
    chk("second_req", u_if.inst_sram_req && u_if.inst_sram_addr == RST_PC + 32'd4,
        u_if.inst_sram_addr, RST_PC + 32'd4);

    // Downstream stall for 5 cycles in HOLD
    allow = 1'b0;
    wait_valid("stall_valid_wait", 10);
    p0 = pc;
    i0 = inst;
    for (int k = 0; k < 5; k++) begin
      chk("stall_hold", valid && pc == p0 && inst == i0 && !u_if.inst_sram_req, pc, p0);
      tick();
    end
    allow = 1'b1;
    tick();
    allow = 1'b0;
    chk("stall_next_req", u_if.inst_sram_req && u_if.inst_sram_addr == p0 + 32'd4,
        u_if.inst_sram_addr, p0 + 32'd4);

    // Branch while waiting for 0x1C00_0008
    chk("wait_req_addr", u_if.inst_sram_addr == 32'h1C00_0008, u_if.inst_sram_addr, 32'h1C00_0008);
    lat = 3;
    tick();
    br_taken = 1'b1; br_tgt = 32'h1C00_0100;
    tick();
    br_taken = 1'b0;
    bad = 1'b0;
    n = 0;
    while (!(u_if.inst_sram_req && u_if.inst_sram_addr_ok) && n < 20) begin
      if (valid) bad = 1'b1;
      tick();
      n++;
    end
    chk("wait_br_no_valid", !bad, 32'(bad), 32'd0);
    chk("wait_br_req", u_if.inst_sram_req && u_if.inst_sram_addr == 32'h1C00_0100,
        u_if.inst_sram_addr, 32'h1C00_0100);
    wait_valid("wait_br_valid_wait", 20);
    chk("wait_br_pc",   pc == 32'h1C00_0100,    pc,   32'h1C00_0100);
    chk("wait_br_inst", inst == ~32'h1C00_0100, inst, ~32'h1C00_0100);

    // Simultaneous exception and branch in HOLD
    excp = 1'b1; excp_tgt = 32'h1C00_4000;
    br_taken = 1'b1; br_tgt = 32'h1C00_0100;
    tick();
    excp = 1'b0; br_taken = 1'b0;
    chk("hold_excp_drop", !valid, 32'(valid), 32'd0);
    wait_req("hold_excp_req_wait", 10);
    chk("hold_excp_req", u_if.inst_sram_addr == 32'h1C00_4000, u_if.inst_sram_addr, 32'h1C00_4000);

    // Redirect with addr_ok, then a second redirect during WAIT
    d0 = dok_cnt;
    br_taken = 1'b1; br_tgt = 32'h1C00_8000;
    tick();
    br_tgt = 32'h0000_2000;
    tick();
    br_taken = 1'b0;
    wait_req("double_req_wait", 20);
    chk("double_req", u_if.inst_sram_addr == 32'h0000_2000, u_if.inst_sram_addr, 32'h0000_2000);
    wait_valid("double_valid_wait", 20);
    chk("double_pc",   pc == 32'h0000_2000 && inst == ~32'h0000_2000, pc, 32'h0000_2000);
    chk("double_resp", (dok_cnt - d0) == 2, 32'(dok_cnt - d0), 32'd2);

    // Redirect vector table
    for (int v = 0; v < 6; v++) begin
      wait_valid("tbl_ready", 20);
      allow = 1'b0;
      excp = tbl[v].excp; excp_tgt = tbl[v].etgt;
      br_taken = tbl[v].br; br_tgt = tbl[v].btgt;
      tick();
      excp = 1'b0; br_taken = 1'b0;
      saw_req = 1'b0;
      n = 0;
      while (!valid && n < 20) begin
        if (u_if.inst_sram_req) saw_req = 1'b1;
        tick();
        n++;
      end
      chk("tbl_req_issued", saw_req == !tbl[v].eadef, 32'(saw_req), 32'(!tbl[v].eadef));
      chk("tbl_pc",   valid && pc == tbl[v].epc, pc,         tbl[v].epc);
      chk("tbl_inst", inst == tbl[v].einst,      inst,       tbl[v].einst);
      chk("tbl_adef", adef == tbl[v].eadef,      32'(adef),  32'(tbl[v].eadef));
      allow = 1'b1;
      tick();
      allow = 1'b0;
      wait_valid("tbl_next_wait", 20);
      chk("tbl_next_pc", pc == tbl[v].enext, pc, tbl[v].enext);
    end

    // Randomized traffic against the fetch-stream model
    okp = 70;
    allow = 1'b0;
    br_taken = 1'b1; br_tgt = 32'h1C00_0000;
    exp_pc = 32'h1C00_0000;
    tick();
    br_taken = 1'b0;
    ncap = 0;
    for (int c = 0; c < 3000; c++) begin
      allow    = int'($urandom_range(99)) < 60;
      r        = int'($urandom_range(99));
      excp     = r < 3;
      br_taken = (r >= 1) && (r < 8);
      excp_tgt = pool[$urandom_range(7)];
      br_tgt   = (r == 7) ? ($urandom & 32'hFFFF_FFFC) : pool[$urandom_range(7)];
      redir    = excp | br_taken;
      tgt      = excp ? excp_tgt : br_tgt;
      if (u_if.inst_sram_req && !redir)
        chk("rnd_req_addr", u_if.inst_sram_addr == exp_pc && exp_pc[1:0] == 2'b00,
            u_if.inst_sram_addr, exp_pc);
      if (valid && allow && !redir) begin
        exp_inst = (exp_pc[1:0] == 2'b00) ? ~exp_pc : NOP;
        chk("rnd_capture", pc == exp_pc && inst == exp_inst && adef == (exp_pc[1:0] != 2'b00),
            pc, exp_pc);
        exp_pc = exp_pc + 32'd4;
        ncap++;
      end
      if (redir) exp_pc = tgt;
      lat = int'($urandom_range(1, 3));
      tick();
    end
    excp = 1'b0; br_taken = 1'b0; allow = 1'b0;
    chk("rnd_progress", ncap > 100, 32'(ncap), 32'd101);

    // Asynchronous reset while holding an entry
    okp = 100;
    wait_valid("rst_mid_wait", 30);
    rst = 1'b1;
    #1;
    chk("rst_mid_clear", !valid && pc == 32'd0 && inst == NOP && !adef && !u_if.inst_sram_req,
        pc, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    wait_req("rst_mid_req_wait", 10);
    chk("rst_mid_req", u_if.inst_sram_addr == RST_PC, u_if.inst_sram_addr, RST_PC);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
